// File: rtl/pmu_quota_pkg.sv
// Shared types for the per-core quota regulator.
package pmu_quota_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StDisabled = 2'd0,
        StReload   = 2'd1,
        StRun      = 2'd2,
        StThrottle = 2'd3
    } quota_reg_state_t;

endpackage

// File: rtl/pmu_quota_regulator_if.sv
// Core-to-bus request handshake that passes through the quota regulator.
interface pmu_quota_regulator_if;

    logic core_valid_i;
    logic core_ready_o;
    logic bus_valid_o;
    logic bus_ready_i;

    // The regulator is the master; the core/bus environment is the slave.
    modport master (
        input  core_valid_i,
        input  bus_ready_i,
        output core_ready_o,
        output bus_valid_o
    );

    modport slave (
        output core_valid_i,
        output bus_ready_i,
        input  core_ready_o,
        input  bus_valid_o
    );

endinterface

// File: rtl/pmu_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pmu_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pmu_quota_regulator.sv
// Opens budget windows, soft-resets the quota monitor at each window start and
// gates the core's request handshake while the quota interrupt is active.
module pmu_quota_regulator
    import pmu_quota_pkg::*;
#(
    parameter int unsigned REG_WIDTH    = 32,
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    enable_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    clear_stats_i,
    input  logic                    intr_quota_i,
    output logic                    quota_softrst_o,
    pmu_quota_regulator_if.master   hs,
    output logic                    throttled_o,
    output logic [REG_WIDTH-1:0]    throttle_cycles_o,
    output logic [REG_WIDTH-1:0]    windows_throttled_o
);

    quota_reg_state_t        state_q, state_d;
    logic [PERIOD_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                    block_q, block_d;
    logic                    blank_q;
    logic                    softrst_q;
    logic                    win_end;
    logic                    stalled;
    logic                    run_to_thr;

    // >= rather than == so that shrinking the period mid-window ends it at once.
    assign win_end = (period_i != '0) && (win_cnt_q >= (period_i - PERIOD_WIDTH'(1)));
    assign stalled = hs.bus_valid_o & ~hs.bus_ready_i;

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StDisabled;
        end else begin
            case (state_q)
                StDisabled: state_d = StReload;
                StReload:   state_d = StRun;
                StRun: begin
                    if (win_end) begin
                        state_d = StReload;
                    end else if (intr_quota_i && !blank_q) begin
                        state_d = StThrottle;
                    end
                end
                StThrottle: begin
                    if (win_end) begin
                        state_d = StReload;
                    end
                end
                default:    state_d = StDisabled;
            endcase
        end
    end

    always_comb begin
        win_cnt_d = win_cnt_q + PERIOD_WIDTH'(1);
        block_d   = block_q;
        if ((state_d == StDisabled) || (state_d == StReload)) begin
            win_cnt_d = '0;
            block_d   = 1'b0;
        end else if ((state_d == StThrottle) && !stalled) begin
            // A beat waiting on the bus is never withdrawn; retry next cycle.
            block_d = 1'b1;
        end
    end

    assign run_to_thr = (state_q == StRun) && (state_d == StThrottle);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StDisabled;
            win_cnt_q <= '0;
            block_q   <= 1'b0;
            blank_q   <= 1'b0;
            softrst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            block_q   <= block_d;
            blank_q   <= (state_q == StReload);
            softrst_q <= (state_d == StReload);
        end
    end

    assign quota_softrst_o = softrst_q;
    assign hs.bus_valid_o  = hs.core_valid_i & ~block_q;
    assign hs.core_ready_o = hs.bus_ready_i & ~block_q;
    assign throttled_o     = block_q;

    pmu_sat_counter #(
        .WIDTH (REG_WIDTH)
    ) u_throttle_cycles (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc    (block_q & hs.core_valid_i),
        .clr    (clear_stats_i),
        .value  (throttle_cycles_o)
    );

    pmu_sat_counter #(
        .WIDTH (REG_WIDTH)
    ) u_windows_throttled (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc    (run_to_thr),
        .clr    (clear_stats_i),
        .value  (windows_throttled_o)
    );

endmodule

// File: tb/tb_pmu_quota_regulator.sv
// Directed bench for pmu_quota_regulator: a per-cycle vector table plus
// hand-written sequences for reload, throttle, stall, saturation and reset.
module tb_pmu_quota_regulator;

    localparam int unsigned RW = 4;
    localparam int unsigned PW = 8;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          en     = 1'b0;
    logic          clr    = 1'b0;
    logic          intr   = 1'b0;
    logic [PW-1:0] period = '0;
    logic          softrst;
    logic          throttled;
    logic [RW-1:0] tc;
    logic [RW-1:0] wt;

    int checks   = 0;
    int failures = 0;

    pmu_quota_regulator_if hs_if ();

    always #5 clk = ~clk;

    pmu_quota_regulator #(
        .REG_WIDTH    (RW),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .enable_i            (en),
        .period_i            (period),
        .clear_stats_i       (clr),
        .intr_quota_i        (intr),
        .quota_softrst_o     (softrst),
        .hs                  (hs_if.master),
        .throttled_o         (throttled),
        .throttle_cycles_o   (tc),
        .windows_throttled_o (wt)
    );

    typedef struct packed {
        logic en;
        logic intr;
        logic cv;
        logic br;
        logic ebv;
        logic ecr;
        logic esr;
        logic eth;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input int p, input logic iq, input logic cv,
                         input logic br, input logic c);
        @(negedge clk);
        en                 = e;
        period             = PW'(p);
        intr               = iq;
        hs_if.core_valid_i = cv;
        hs_if.bus_ready_i  = br;
        clr                = c;
        #1;
    endtask

    initial begin
        // Period 4: reload at v4, v8, v12; throttle at v7; collision at v11.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        hs_if.core_valid_i = 1'b1;
        hs_if.bus_ready_i  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_softrst", int'(softrst), 0);
        chk("rst_throttled", int'(throttled), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_wt", int'(wt), 0);
        chk("rst_bv", int'(hs_if.bus_valid_o), 1);
        @(negedge clk);
        rstn = 1'b1;

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].en, 4, vecs[k].intr, vecs[k].cv, vecs[k].br, 1'b0);
            chk($sformatf("vec%0d_bv", k), int'(hs_if.bus_valid_o), int'(vecs[k].ebv));
            chk($sformatf("vec%0d_cr", k), int'(hs_if.core_ready_o), int'(vecs[k].ecr));
            chk($sformatf("vec%0d_sr", k), int'(softrst), int'(vecs[k].esr));
            chk($sformatf("vec%0d_th", k), int'(throttled), int'(vecs[k].eth));
        end
        chk("tbl_wt_collision", int'(wt), 1);
        chk("tbl_tc", int'(tc), 1);

        // Periodic reload, P=8: pulses at cycles 1, 9, 17.
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 8, 1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("per_sr%0d", i), int'(softrst), int'((i >= 1) && (((i - 1) % 8) == 0)));
        end
        drive(1'b0, 8, 1'b0, 1'b1, 1'b1, 1'b0);

        // Throttle, P=16: interrupt at RUN cycle 5 (cycle 6), gate 7..16, reload at 17.
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 16, (i >= 6) && (i <= 16), 1'b1, 1'b1, 1'b0);
            chk($sformatf("thr_bv%0d", i), int'(hs_if.bus_valid_o), int'(!((i >= 7) && (i <= 16))));
            chk($sformatf("thr_sr%0d", i), int'(softrst), int'((i == 1) || (i == 17)));
        end
        chk("thr_wt", int'(wt), 2);
        chk("thr_tc", int'(tc), 11);
        drive(1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0);

        // Stalled beat at the interrupt; gate only after acceptance at cycle 9.
        // Then saturation of the 4-bit cycle counter and a clear that beats increment.
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 16, (i >= 6) && (i <= 16), 1'b1, !((i >= 6) && (i <= 8)), i == 16);
            if ((i >= 6) && (i <= 9)) chk($sformatf("stl_bv%0d", i), int'(hs_if.bus_valid_o), 1);
            if (i == 7) chk("stl_cr7", int'(hs_if.core_ready_o), 0);
            if (i == 9) chk("stl_cr9", int'(hs_if.core_ready_o), 1);
            if (i == 10) begin
                chk("stl_bv10", int'(hs_if.bus_valid_o), 0);
                chk("stl_th10", int'(throttled), 1);
                chk("stl_tc10", int'(tc), 11);
            end
            if ((i == 14) || (i == 16)) chk($sformatf("sat_tc%0d", i), int'(tc), 15);
            if (i == 16) chk("stl_wt16", int'(wt), 3);
            if (i == 17) begin
                chk("clr_tc17", int'(tc), 0);
                chk("clr_wt17", int'(wt), 0);
            end
            if (i == 18) chk("clr_tc18", int'(tc), 0);
        end
        drive(1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset asserted mid-throttle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16, i >= 3, 1'b1, 1'b1, 1'b0);
        end
        chk("pre_rst_th", int'(throttled), 1);
        chk("pre_rst_tc", int'(tc), 3);
        chk("pre_rst_wt", int'(wt), 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_th", int'(throttled), 0);
        chk("mid_rst_sr", int'(softrst), 0);
        chk("mid_rst_bv", int'(hs_if.bus_valid_o), 1);
        chk("mid_rst_tc", int'(tc), 0);
        chk("mid_rst_wt", int'(wt), 0);
        @(negedge clk);
        en   = 1'b0;
        intr = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("post_rst_sr%0d", i), int'(softrst), 0);
        end
        drive(1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("reen_sr0", int'(softrst), 0);
        drive(1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("reen_sr1", int'(softrst), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmu_quota_regulator.md
# pmu_quota_regulator

Per-core bandwidth regulator that drives the quota monitor and enforces its verdict. It opens fixed-length budget windows, pulses the quota unit's soft reset at each window start, and consumes the quota interrupt. While the interrupt is active it throttles the core's outgoing request handshake until the window ends. It sits between one core's memory-request port and the bus, next to that core's quota monitor inside the PMU.

## Interface
- `REG_WIDTH`, 32: width of the statistics counters.
- `PERIOD_WIDTH`, 32: width of the window-length register and window counter.
- `clk_i` in 1: clock.
- `rstn_i` in 1: asynchronous reset, active-low.
- `enable_i` in 1: regulation enable, level.
- `period_i` in PERIOD_WIDTH: window length in cycles. 0 means no periodic reload.
- `clear_stats_i` in 1: synchronous clear of the statistics counters, pulse.
- `intr_quota_i` in 1: quota-exceeded interrupt from the quota monitor.
- `quota_softrst_o` out 1: soft reset to the quota monitor, one-cycle pulse.
- `core_valid_i` in 1 / `core_ready_o` out 1: core-side request handshake.
- `bus_valid_o` out 1 / `bus_ready_i` in 1: bus-side request handshake.
- `throttled_o` out 1: throttle gate currently applied.
- `throttle_cycles_o` out REG_WIDTH: saturating count of cycles with `block_q`=1 and `core_valid_i`=1.
- `windows_throttled_o` out REG_WIDTH: saturating count of windows that entered THROTTLE.

## Operation
- **FSM states:** DISABLED, RELOAD, RUN, THROTTLE.
- **DISABLED**
  - Traffic passes through; the window counter is held at 0.
  - `enable_i`=1 moves to RELOAD.
- **RELOAD** (exactly one cycle)
  - `quota_softrst_o`=1; window counter is 0; traffic passes.
  - Always moves to RUN. If `enable_i`=0, it moves to DISABLED instead.
- **RUN**
  - The window counter increments each cycle.
  - If `period_i`≠0 and `win_cnt >= period_i-1`, move to RELOAD. The `>=` compare makes a shrinking `period_i` take effect immediately.
  - Otherwise, if `intr_quota_i`=1, move to THROTTLE.
  - `intr_quota_i` is ignored in the first RUN cycle after RELOAD (one-cycle blanking).
- **THROTTLE**
  - The window counter continues.
  - Window end moves to RELOAD.
  - `enable_i`=0 moves to DISABLED from any state and has priority over every other transition.
- **Simultaneous events:** window end beats interrupt (RELOAD wins). In that case `windows_throttled_o` does not increment.
- **Gating register `block_q`**
  - Sets at the edge where next state is THROTTLE and no beat is stalled. A stalled beat is `bus_valid_o`=1 and `bus_ready_i`=0 in the current cycle.
  - If a beat is stalled, setting is retried every THROTTLE cycle. An accepted or in-flight beat is never withdrawn.
  - Clears at the edge into RELOAD or DISABLED.
- **Handshake outputs**
  - `bus_valid_o = core_valid_i & ~block_q`
  - `core_ready_o = bus_ready_i & ~block_q`
  - `throttled_o = block_q`
- **Statistics**
  - `windows_throttled_o` increments on each RUN→THROTTLE edge.
  - Both statistics counters saturate at all-ones.
  - `clear_stats_i` zeroes both counters; it has priority over increment in the same cycle.
- **Reset values:** state DISABLED, `win_cnt`=0, `block_q`=0, `quota_softrst_o`=0, both statistics counters=0.
  - The handshake outputs then follow the inputs combinationally.

## Timing
- Interrupt at cycle t in RUN, no stalled beat → `bus_valid_o`=0 from t+1.
- If a beat is stalled at t, `block_q` sets one cycle after that beat is accepted, provided the state is still THROTTLE.
- With `period_i`=P, RELOAD recurs every P cycles: one RELOAD plus P-1 RUN/THROTTLE cycles.
- `quota_softrst_o` is registered (driven from state) and is high for exactly the RELOAD cycle.
- The quota monitor's interrupt is therefore clear in the cycle after RELOAD.
- Reset assertion mid-window: immediate return to reset values, with no softrst pulse.

## Structure
- Shared package `pmu_quota_pkg`:
  - `quota_reg_state_t` enum (DISABLED, RELOAD, RUN, THROTTLE), 2 bits.
  - Localparam for the state width.
- Sub-module `pmu_sat_counter` (parameter WIDTH; ports: inc, clr, value; saturating): instantiated twice, once per statistics counter.
- FSM, window counter and gate stay in the top module.

## Test plan
- **Pass-through:** `enable_i`=0, `core_valid_i`=1, `bus_ready_i`=1 for 10 cycles → `bus_valid_o`=1 and `core_ready_o`=1 every cycle; `quota_softrst_o` never pulses.
- **Periodic reload:** `enable_i`=1, `period_i`=8 → `quota_softrst_o` pulses one cycle every 8 cycles, starting the cycle after enable.
- **Throttle:** P=16, `intr_quota_i`=1 at RUN cycle 5, `bus_ready_i`=1 → `bus_valid_o`=0 from cycle 6 until RELOAD; traffic resumes in the RELOAD cycle; `windows_throttled_o`=1.
- **Stalled beat:** `bus_ready_i`=0 with `core_valid_i`=1 when `intr_quota_i` rises → `bus_valid_o` stays 1 until `bus_ready_i`=1, then drops the next cycle.
- **Collision:** `intr_quota_i`=1 exactly on the last window cycle → RELOAD taken, `block_q` stays 0, counter unchanged.
- **Saturation:** force `throttle_cycles_o` to all-ones, throttle for 3 more cycles → value stays all-ones; `clear_stats_i` pulse → 0.
